mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency memory between the multicycle CPU's
//  instruction-fetch requester (port 0) and data load/store requester (port 1).
//  Round-robin arbitration, one outstanding access at a time, registered
//  request capture, and a one-cycle completion pulse back to the owner.
//  Sits between the controller/datapath and the unified memory.
// PARAMETERS
//  AW       32  address width (bits)
//  DW       32  data width (bits)
//  MEM_LAT  1   cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
// PORTS
//  clk        in   1    system clock, rising edge
//  reset      in   1    asynchronous, active-high reset
//  req        in   2    access request per port (bit0 fetch, bit1 data)
//  we         in   2    per-port write enable; 1=write, 0=read
//  addr0      in   AW   port 0 address
//  addr1      in   AW   port 1 address
//  wdata1     in   DW   port 1 write data (port 0 is read-only; we[0] ignored)
//  gnt        out  2    one-hot one-cycle pulse: request captured
//  rvalid     out  2    one-hot one-cycle pulse: access complete
//  rdata      out  DW   read data, valid while rvalid is high
//  busy       out  1    high in every state except IDLE
//  mem_en     out  1    memory strobe, one cycle per access
//  mem_we     out  1    memory write enable, qualified by mem_en
//  mem_addr   out  AW   memory address
//  mem_wdata  out  DW   memory write data
//  mem_rdata  in   DW   memory read data
// BEHAVIOUR
//  Reset (async) forces state=IDLE and owner=0; last_gnt=1, so port 0 has
//  priority first. Forces gnt, rvalid, mem_en, mem_we, busy to 0, and
//  mem_addr, mem_wdata, rdata to 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if any req bit is set, pick a winner combinationally.
//    - A single requester wins.
//    - If both request, the port != last_gnt wins.
//    - In the same cycle, drive gnt[winner]=1. At the edge, capture addr,
//      we, and wdata into mem_addr, mem_we, and mem_wdata. Set
//      owner=last_gnt=winner and go to ISSUE.
//    - With no req, stay in IDLE.
//  - ISSUE (1 cycle): mem_en=1. Load the wait counter with MEM_LAT-1 and
//    go to WAIT.
//  - WAIT (MEM_LAT cycles): decrement the counter. When it reaches 0,
//    capture mem_rdata into rdata on reads (rdata holds on writes) and
//    go to RESP.
//  - RESP (1 cycle): rvalid[owner]=1, then go to IDLE.
//  Latency, with gnt at cycle 0: mem_en at cycle 1, mem_rdata sampled at
//  the end of cycle 1+MEM_LAT, rvalid at cycle 2+MEM_LAT.
//  Throughput: one access per MEM_LAT+3 cycles.
//  Requests arriving while busy are not captured. The requester must hold
//  req, addr, and wdata until it sees gnt. A req that drops before gnt is
//  simply never served (no error).
//  After gnt, input changes have no effect on the access in flight.
//  gnt and rvalid are never both high in one cycle, and each has at most
//  one bit set.
//  mem_addr, mem_wdata, and mem_we hold their values from capture until the
//  next capture. mem_we is meaningful only while mem_en=1.
//  Reset mid-access: the access is abandoned. No rvalid is issued, and
//  mem_en/mem_we drop immediately.
// TESTING
//  1. Single read: req=01, addr0=0x10, MEM_LAT=1, mem_rdata=0xDEADBEEF ->
//     gnt=01 at c0, mem_en at c1, rvalid=01 with rdata=0xDEADBEEF at c3.
//  2. Write: req=10, we=10, addr1=0x20, wdata1=0x55 -> mem_en=mem_we=1 at
//     c1, mem_addr=0x20, mem_wdata=0x55, rvalid=10 at c3, rdata unchanged.
//  3. Contention after reset: req=11 held -> grants alternate
//     port0, port1, port0, spaced MEM_LAT+3 cycles apart.
//  4. Request while busy: port 1 asserts req during port 0's WAIT -> no
//     gnt until the IDLE after port 0's RESP, then gnt=10.
//  5. Reset at c2 of a read -> all outputs 0 immediately. No rvalid ever
//     appears. The next req=01 is served normally.
//  6. MEM_LAT=4: the read completes with rvalid at c6, and rdata equals
//     mem_rdata as presented during c5.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory between fetch and data ports
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req[1:0], we[1:0]   per-port request / write enable (bit0 fetch, bit1 data; we[0] ignored)
//   addr0, addr1        per-port address
//   wdata1              data-port write data
//   gnt[1:0]            one-cycle pulse: request captured
//   rvalid[1:0]         one-cycle pulse: access complete, rdata valid
//   rdata               read data
//   busy                high whenever not idle
//   mem_en, mem_we      memory strobe and write enable
//   mem_addr, mem_wdata memory address and write data
//   mem_rdata           memory read data
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_gnt_q, last_gnt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          winner;

    // On contention the port that did not win last time goes next.
    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_gnt_q;
        end else begin
            winner = req[1];
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt         = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt        = winner ? 2'b10 : 2'b01;
                    owner_d    = winner;
                    last_gnt_d = winner;
                    state_d    = ISSUE;
                    if (winner) begin
                        mem_addr_d  = addr1;
                        mem_we_d    = we[1];
                        mem_wdata_d = wdata1;
                    end else begin
                        // Fetch port is read-only; mem_wdata keeps its last value.
                        mem_addr_d = addr0;
                        mem_we_d   = 1'b0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b1;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Strobe and status decode straight from state so reset clears them at once.
    assign rvalid    = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, LAT = 1, LATB = 4;
    localparam logic [31:0] GARB = 32'hBAD0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [1:0]    req = 2'b00, we = 2'b00, req_b = 2'b00;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata1 = '0, mrd = GARB, mrd_b = GARB;
    logic [1:0]    gnt, rvalid, gnt_b, rvalid_b;
    logic [DW-1:0] rdata, mem_wdata, rdata_b, mem_wdata_b;
    logic [AW-1:0] mem_addr, mem_addr_b;
    logic          busy, mem_en, mem_we, busy_b, mem_en_b, mem_we_b;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata1(wdata1), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mrd));

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LATB)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata1(wdata1), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mrd_b));

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: expected grant port, expected {port, rdata}.
    int          gnt_q[$], gnt_qb[$];
    logic [32:0] rsp_q[$], rsp_qb[$];
    int          gcyc[2], gcyc_b[2];

    // Memory model A: presents stored data only in the cycle MEM_LAT after mem_en.
    logic [31:0] mem [256];
    int          left = 0, left_b = 0;
    logic [7:0]  pa;
    always @(negedge clk) begin
        if (reset) begin
            left = 0;
            mrd  = GARB;
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[8'h10] = 32'hDEADBEEF;
            mem[8'h30] = 32'h12345678;
        end else if (left > 0) begin
            left--;
            mrd = (left == 0) ? mem[pa] : (GARB | 32'(cyc));
        end else begin
            mrd = GARB | 32'(cyc);
            if (mem_en) begin
                pa   = mem_addr[7:0];
                left = LAT;
                if (mem_we) mem[pa] = mem_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            left_b = 0;
            mrd_b  = GARB;
        end else if (left_b > 0) begin
            left_b--;
            mrd_b = (left_b == 0) ? 32'hCAFE0004 : (GARB | 32'(cyc));
        end else begin
            mrd_b = GARB | 32'(cyc);
            if (mem_en_b) left_b = LATB;
        end
    end

    // Monitor A
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != 2'b00) begin
                if (gnt_q.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'd0);
                else chk("gnt", 64'(gnt), (gnt_q.pop_front() == 0) ? 64'd1 : 64'd2);
                gcyc[gnt[1]] = cyc;
            end
            if (rvalid != 2'b00) begin
                chk("no_gnt_with_rvalid", 64'(gnt), 64'd0);
                if (rsp_q.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 64'd0);
                else begin
                    logic [32:0] e;
                    e = rsp_q.pop_front();
                    chk("rvalid_port", 64'(rvalid), e[32] ? 64'd2 : 64'd1);
                    chk("rdata", 64'(rdata), 64'(e[31:0]));
                    chk("rvalid_latency", 64'(cyc - gcyc[rvalid[1]]), 64'(2 + LAT));
                end
            end
        end
    end

    // Monitor B (MEM_LAT=4 instance)
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt_b != 2'b00) begin
                if (gnt_qb.size() == 0) chk("b_unexpected_gnt", 64'(gnt_b), 64'd0);
                else chk("b_gnt", 64'(gnt_b), (gnt_qb.pop_front() == 0) ? 64'd1 : 64'd2);
                gcyc_b[gnt_b[1]] = cyc;
            end
            if (rvalid_b != 2'b00) begin
                if (rsp_qb.size() == 0) chk("b_unexpected_rvalid", 64'(rvalid_b), 64'd0);
                else begin
                    logic [32:0] e;
                    e = rsp_qb.pop_front();
                    chk("b_rvalid_port", 64'(rvalid_b), e[32] ? 64'd2 : 64'd1);
                    chk("b_rdata", 64'(rdata_b), 64'(e[31:0]));
                    chk("b_rvalid_latency", 64'(cyc - gcyc_b[rvalid_b[1]]), 64'(2 + LATB));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // Issue one access on DUT A; returns in the cycle after gnt (c1).
    task automatic access(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, output int c0);
        int n;
        gnt_q.push_back(p);
        rsp_q.push_back({p[0], exp_rd});
        if (p == 0) addr0 = a;
        else begin
            addr1  = a;
            wdata1 = d;
            we[1]  = w;
        end
        req[p] = 1'b1;
        n = 0;
        @(negedge clk);
        while (gnt[p] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("gnt_timeout", 64'(gnt[p]), 64'd1);
        c0 = cyc;
        tick();
        req[p] = 1'b0;
        we     = 2'b00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        int c0;
        int g[3];
        int n;
        logic seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({gnt, rvalid, busy, mem_en, mem_we}), 64'd0);
        chk("reset_data", 64'({mem_addr, mem_wdata}), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        tick();

        // Single read on port 0
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c0);
        @(negedge clk);
        chk("t1_mem_en", 64'({mem_en, mem_we}), 64'd2);
        chk("t1_mem_en_cycle", 64'(cyc), 64'(c0 + 1));
        chk("t1_mem_addr", 64'(mem_addr), 64'h10);
        wait_idle();

        // Write on port 1; rdata must keep the previous read value
        access(1, 1'b1, 32'h20, 32'h55, 32'hDEADBEEF, c0);
        @(negedge clk);
        chk("t2_mem_en_we", 64'({mem_en, mem_we}), 64'd3);
        chk("t2_mem_addr", 64'(mem_addr), 64'h20);
        chk("t2_mem_wdata", 64'(mem_wdata), 64'h55);
        wait_idle();

        // Read back the written word via port 0
        access(0, 1'b0, 32'h20, 32'h0, 32'h00000055, c0);
        wait_idle();

        // Port 1 request during port 0 WAIT is held off until IDLE
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c0);
        tick();
        gnt_q.push_back(1);
        rsp_q.push_back({1'b1, 32'h12345678});
        addr1 = 32'h30;
        req   = 2'b10;
        @(negedge clk);
        chk("t4_no_gnt_wait", 64'(gnt), 64'd0);
        tick();
        @(negedge clk);
        chk("t4_no_gnt_resp", 64'(gnt), 64'd0);
        tick();
        @(negedge clk);
        chk("t4_gnt_after", 64'(gnt), 64'd2);
        chk("t4_gnt_cycle", 64'(cyc), 64'(c0 + LAT + 3));
        tick();
        req = 2'b00;
        wait_idle();

        // Contention after reset: 0, 1, 0 spaced MEM_LAT+3
        do_reset();
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0);
        rsp_q.push_back({1'b0, 32'hDEADBEEF});
        rsp_q.push_back({1'b1, 32'h12345678});
        rsp_q.push_back({1'b0, 32'hDEADBEEF});
        addr0 = 32'h10;
        addr1 = 32'h30;
        req   = 2'b11;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (gnt == 2'b00 && n < 40);
            if (n >= 40) chk("t3_gnt_timeout", 64'(gnt), 64'd1);
            g[k] = cyc;
        end
        tick();
        req = 2'b00;
        chk("t3_spacing_a", 64'(g[1] - g[0]), 64'(LAT + 3));
        chk("t3_spacing_b", 64'(g[2] - g[1]), 64'(LAT + 3));
        wait_idle();

        // Reset in c2 of a read abandons it
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        rsp_q.delete();
        chk("t5_ctrl", 64'({gnt, rvalid, busy, mem_en, mem_we}), 64'd0);
        chk("t5_data", 64'({mem_addr, mem_wdata}), 64'd0);
        chk("t5_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | (|rvalid);
        end
        chk("t5_no_rvalid", 64'(seen), 64'd0);
        tick();
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c0);
        wait_idle();

        // MEM_LAT=4 instance: rdata must be mem_rdata from c5
        gnt_qb.push_back(0);
        rsp_qb.push_back({1'b0, 32'hCAFE0004});
        addr0 = 32'h40;
        req_b = 2'b01;
        n = 0;
        @(negedge clk);
        while (gnt_b !== 2'b01 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("t6_gnt_timeout", 64'(gnt_b), 64'd1);
        tick();
        req_b = 2'b00;
        n = 0;
        while (rsp_qb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("t6_rvalid_timeout", 64'(rsp_qb.size()), 64'd0);
        repeat (2) @(negedge clk);

        chk("queues_drained", 64'(gnt_q.size() + rsp_q.size() + gnt_qb.size() + rsp_qb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
